// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the register file's single write port between the ALU and the
// load/store writeback source. Ties go round-robin, and the granted request
// is registered into the write stage. A busy bit per register tracks issued
// but not yet written destinations, so decode can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst                       clock; asynchronous active-low reset
//   alu_valid/ready/addr/data      ALU writeback request (valid/ready handshake)
//   mem_valid/ready/addr/data      load writeback request (valid/ready handshake)
//   issue_valid, issue_addr        decode issues an instruction writing issue_addr
//   chk_addr_a/b/c                 source registers of the instruction in decode
//   hazard                         a checked source or the issued dest is busy
//   we, waddr, wdata               register file write port (registered)

module regfile_wb_arbiter #(
    parameter int unsigned RADDRWIDTH = 3,
    parameter int unsigned REGWIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [RADDRWIDTH-1:0] alu_addr,
    input  logic [REGWIDTH-1:0]   alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [RADDRWIDTH-1:0] mem_addr,
    input  logic [REGWIDTH-1:0]   mem_data,
    input  logic                  issue_valid,
    input  logic [RADDRWIDTH-1:0] issue_addr,
    input  logic [RADDRWIDTH-1:0] chk_addr_a,
    input  logic [RADDRWIDTH-1:0] chk_addr_b,
    input  logic [RADDRWIDTH-1:0] chk_addr_c,
    output logic                  hazard,
    output logic                  we,
    output logic [RADDRWIDTH-1:0] waddr,
    output logic [REGWIDTH-1:0]   wdata
);

    localparam int unsigned NumRegs = 2 ** RADDRWIDTH;

    typedef enum logic {SrcAlu, SrcMem} src_e;

    src_e                  last_q, last_d;
    logic                  alu_grant, mem_grant;
    logic                  we_d;
    logic [RADDRWIDTH-1:0] waddr_d;
    logic [REGWIDTH-1:0]   wdata_d;
    logic [NumRegs-1:0]    busy_q, busy_d;

    // Round-robin: a lone requester always wins; on a tie the source that was
    // not granted most recently wins.
    always_comb begin
        alu_grant = alu_valid && (!mem_valid || (last_q == SrcMem));
        mem_grant = mem_valid && (!alu_valid || (last_q == SrcAlu));
    end

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    always_comb begin
        last_d  = last_q;
        we_d    = 1'b0;
        waddr_d = waddr;
        wdata_d = wdata;
        if (alu_grant) begin
            last_d  = SrcAlu;
            we_d    = (alu_addr != '0);  // r0 is accepted but never written
            waddr_d = alu_addr;
            wdata_d = alu_data;
        end else if (mem_grant) begin
            last_d  = SrcMem;
            we_d    = (mem_addr != '0);
            waddr_d = mem_addr;
            wdata_d = mem_data;
        end
    end

    // Clear on commit first, then set, so a newer producer issued on the same
    // edge keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[waddr] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        hazard = busy_q[chk_addr_a] | busy_q[chk_addr_b] | busy_q[chk_addr_c] |
                 (issue_valid & busy_q[issue_addr]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= SrcMem;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
            busy_q <= '0;
        end else begin
            last_q <= last_d;
            we     <= we_d;
            waddr  <= waddr_d;
            wdata  <= wdata_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [2:0]  mem_addr;
    logic [15:0] mem_data;
    logic        issue_valid;
    logic [2:0]  issue_addr;
    logic [2:0]  chk_addr_a, chk_addr_b, chk_addr_c;
    logic        hazard;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;

    int checks   = 0;
    int failures = 0;

    // Reference model state: who won last (0 = ALU, 1 = mem), busy set, and
    // the write that should currently be on the register file port.
    int          m_last;
    bit          m_busy[8];
    bit          m_we;
    logic [2:0]  m_waddr;
    logic [15:0] m_wdata;

    // Per-step results: model grants and observed DUT values.
    bit   g_alu, g_mem;
    logic o_ar, o_mr, o_hz, o_we;

    regfile_wb_arbiter #(
        .RADDRWIDTH(3),
        .REGWIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .chk_addr_a (chk_addr_a),
        .chk_addr_b (chk_addr_b),
        .chk_addr_c (chk_addr_c),
        .hazard     (hazard),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard();
        bit h;
        h = m_busy[chk_addr_a] || m_busy[chk_addr_b] || m_busy[chk_addr_c];
        if (issue_valid && m_busy[issue_addr]) h = 1'b1;
        return h;
    endfunction

    task automatic model_reset();
        m_last  = 1;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    endtask

    // One clock cycle: inputs were set after the previous posedge; compare at
    // the negedge, then advance the model across the posedge.
    task automatic step();
        @(negedge clk);
        if (alu_valid && mem_valid) begin
            g_alu = (m_last == 1);
            g_mem = !g_alu;
        end else begin
            g_alu = alu_valid;
            g_mem = mem_valid;
        end
        o_ar = alu_ready;
        o_mr = mem_ready;
        o_hz = hazard;
        o_we = we;
        chk("alu_ready", 32'(alu_ready), 32'(g_alu));
        chk("mem_ready", 32'(mem_ready), 32'(g_mem));
        chk("we", 32'(we), 32'(m_we));
        if (m_we) begin
            chk("waddr", 32'(waddr), 32'(m_waddr));
            chk("wdata", 32'(wdata), 32'(m_wdata));
        end
        chk("hazard", 32'(hazard), 32'(model_hazard()));
        @(posedge clk);
        if (m_we) m_busy[m_waddr] = 1'b0;
        if (issue_valid && issue_addr != 3'd0) m_busy[issue_addr] = 1'b1;
        if (g_alu) begin
            m_we = (alu_addr != 3'd0); m_waddr = alu_addr; m_wdata = alu_data; m_last = 0;
        end else if (g_mem) begin
            m_we = (mem_addr != 3'd0); m_waddr = mem_addr; m_wdata = mem_data; m_last = 1;
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    initial begin
        int  ai, mi, k;
        bit  pa, pm;

        rst = 1'b0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        issue_valid = 0; issue_addr = 0;
        chk_addr_a = 0; chk_addr_b = 0; chk_addr_c = 0;
        model_reset();
        #2;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single source
        alu_valid = 1; alu_addr = 3'd3; alu_data = 16'h1234;
        step();
        chk("single_ready", 32'(o_ar), 32'd1);
        alu_valid = 0;
        step();
        chk("single_we_c1", 32'(o_we), 32'd1);
        step();
        chk("single_we_c2", 32'(o_we), 32'd0);

        // Scoreboard RAW on r5
        issue_valid = 1; issue_addr = 3'd5; chk_addr_a = 3'd5;
        step();
        issue_valid = 0;
        step();
        chk("raw_hz_c1", 32'(o_hz), 32'd1);
        step();
        mem_valid = 1; mem_addr = 3'd5; mem_data = 16'h5555;
        step();
        chk("raw_mem_grant", 32'(o_mr), 32'd1);
        mem_valid = 0;
        step();
        chk("raw_hz_c4", 32'(o_hz), 32'd1);
        step();
        chk("raw_hz_c5", 32'(o_hz), 32'd0);
        chk_addr_a = 0;

        // Set/clear collision on r2
        issue_valid = 1; issue_addr = 3'd2;
        step();
        issue_valid = 0;
        alu_valid = 1; alu_addr = 3'd2; alu_data = 16'h2222;
        step();
        alu_valid = 0;
        issue_valid = 1; issue_addr = 3'd2;
        step();
        chk("coll_we", 32'(o_we), 32'd1);
        issue_valid = 0; chk_addr_a = 3'd2;
        step();
        chk("coll_busy", 32'(o_hz), 32'd1);
        chk_addr_a = 0;

        // Register 0
        alu_valid = 1; alu_addr = 3'd0; alu_data = 16'hffff;
        issue_valid = 1; issue_addr = 3'd0;
        step();
        chk("r0_ready", 32'(o_ar), 32'd1);
        chk("r0_hazard", 32'(o_hz), 32'd0);
        alu_valid = 0; issue_valid = 0;
        step();
        chk("r0_we", 32'(o_we), 32'd0);

        // Asynchronous reset while a write is in the write stage
        issue_valid = 1; issue_addr = 3'd5;
        step();
        issue_valid = 0; chk_addr_b = 3'd5;
        alu_valid = 1; alu_addr = 3'd6; alu_data = 16'h6666;
        step();
        alu_valid = 0;
        chk("pre_rst_we", 32'(we), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_waddr", 32'(waddr), 32'd0);
        chk("arst_wdata", 32'(wdata), 32'd0);
        chk("arst_hazard", 32'(hazard), 32'd0);
        model_reset();
        #1 rst = 1'b1;
        chk_addr_b = 0;

        // Contention: first tie after reset must go to the ALU
        ai = 0; mi = 0; k = 0;
        while ((ai < 4 || mi < 3) && k < 20) begin
            alu_valid = (ai < 4); alu_addr = 3'(ai + 1); alu_data = 16'(16'h0a00 + ai);
            mem_valid = (mi < 3); mem_addr = 3'(mi + 5); mem_data = 16'(16'h0b00 + mi);
            step();
            if (k < 4) begin
                chk("cont_order", 32'(o_ar), 32'((k % 2) == 0));
                chk("cont_one_ready", 32'(o_ar & o_mr), 32'd0);
            end
            if (g_alu) ai++;
            if (g_mem) mi++;
            k++;
        end
        chk("cont_done", 32'(k), 32'd7);
        alu_valid = 0; mem_valid = 0;
        step();

        // Randomized traffic; requesters hold until accepted
        pa = 0; pm = 0;
        for (int c = 0; c < 500; c++) begin
            if (!pa && ($urandom_range(0, 1) == 1)) begin
                pa = 1; alu_addr = 3'($urandom_range(0, 7)); alu_data = 16'($urandom);
            end
            if (!pm && ($urandom_range(0, 1) == 1)) begin
                pm = 1; mem_addr = 3'($urandom_range(0, 7)); mem_data = 16'($urandom);
            end
            alu_valid = pa;
            mem_valid = pm;
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_addr = 3'($urandom_range(0, 7));
            chk_addr_a = 3'($urandom_range(0, 7));
            chk_addr_b = 3'($urandom_range(0, 7));
            chk_addr_c = 3'($urandom_range(0, 7));
            step();
            if (g_alu) pa = 0;
            if (g_mem) pm = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 3-read/1-write register file. Shares the single write port between the ALU and load/store writeback sources with round-robin arbitration and a registered write stage. Keeps a pending-write scoreboard (one busy bit per register) so decode can stall on RAW/WAW hazards. Sits between the execute/memory stages and the register file's `we`/`waddr`/`wdata` inputs.

## Interface
- `RADDRWIDTH`, 3, register address width; 2**RADDRWIDTH registers, register 0 hardwired zero
- `REGWIDTH`, 16, data width
- `clk` in 1: sole clock, all state on posedge
- `rst` in 1: reset, asynchronous, active-low (asserted when 0)
- `alu_valid` in 1: ALU writeback request
- `alu_ready` out 1: ALU request granted this cycle
- `alu_addr` in RADDRWIDTH: ALU destination register
- `alu_data` in REGWIDTH: ALU result
- `mem_valid` in 1: load writeback request
- `mem_ready` out 1: load request granted this cycle
- `mem_addr` in RADDRWIDTH: load destination register
- `mem_data` in REGWIDTH: load data
- `issue_valid` in 1: decode issues an instruction that will write `issue_addr`
- `issue_addr` in RADDRWIDTH: destination of issued instruction
- `chk_addr_a`, `chk_addr_b`, `chk_addr_c` in RADDRWIDTH each: source registers of instruction in decode
- `hazard` out 1: any checked source or `issue_addr` (when `issue_valid`) is busy
- `we` out 1: register file write enable
- `waddr` out RADDRWIDTH: register file write address
- `wdata` out REGWIDTH: register file write data

## Operation
- Handshake: transfer on `x_valid && x_ready`. `x_ready` is combinational from valids and arbiter state; at most one ready high per cycle. Requester holds valid/addr/data stable until accepted.
- Arbitration: one valid → that requester granted. Both valid → requester not granted most recently wins. Pointer `last` updates only on a grant. Reset value of `last` = mem, so ALU wins first tie.
- Write stage: granted request registered into `we`/`waddr`/`wdata` at next posedge. No grant → `we`=0, `waddr`/`wdata` hold previous values. Write stage never backpressures; throughput one write/cycle.
- Address 0: request accepted normally (ready asserted, pointer updates), but `we` stays 0 for it.
- Scoreboard: `busy[i]`, bit 0 constant 0.
  - Set: `issue_valid && issue_addr != 0` sets `busy[issue_addr]` at posedge.
  - Clear: `we && waddr == i` clears `busy[i]` at posedge (same edge the register file commits the write).
  - Same edge set and clear on the same register: set wins (newer producer outstanding).
- `hazard` combinational: `busy[chk_addr_a] | busy[chk_addr_b] | busy[chk_addr_c] | (issue_valid & busy[issue_addr])`. Address 0 never hazards. Decode must not issue while `hazard`=1; when it does, set is still applied (no protection in this block).
- Writeback for a register not marked busy is legal; it is written, scoreboard unaffected.

## Timing
- Reset (`rst`=0): immediately `we`=0, `waddr`=0, `wdata`=0, all `busy`=0, `last`=mem; `alu_ready`/`mem_ready` follow combinationally from valids. Write held in write stage at reset is dropped. Deassertion takes effect at next posedge.
- Grant in cycle N → `we`=1 in cycle N+1 → register file updated and `busy` cleared at end of N+1 → read in N+2 returns new value, `hazard` low from N+2.
- Issue in cycle N → `busy` set and `hazard` visible from N+1.
- Back-to-back: both valid continuously → grants alternate each cycle, `we` high every cycle from the second.

## Test plan
- Reset: drive `rst`=0 mid-write with `we`=1 → `we`=0, `waddr`=0, `wdata`=0, `hazard`=0 asynchronously; after release first tie grants ALU.
- Single source: `alu_valid`=1, `alu_addr`=3, `alu_data`=16'h1234 in cycle 0 → `alu_ready`=1 cycle 0; cycle 1 `we`=1, `waddr`=3, `wdata`=16'h1234; cycle 2 `we`=0.
- Contention: both valid for 4 cycles, ALU→r1..r4 data, mem→r5..r7 → grant order ALU,mem,ALU,mem; writes seen one cycle later in that order; no cycle with both readies.
- Scoreboard RAW: issue r5 cycle 0; `chk_addr_a`=5 → `hazard`=1 from cycle 1; mem writes r5 granted cycle 3 → `we` cycle 4, `hazard`=0 cycle 5.
- Set/clear collision: r2 busy, write to r2 in write stage while `issue_valid`, `issue_addr`=2 same cycle → `busy[2]` remains 1 after edge.
- Register 0: ALU request to r0 → `alu_ready`=1, next cycle `we`=0; `issue_addr`=0 and `chk_addr_*`=0 → `hazard`=0.
